aes_dec_host: RTL and testbench
===============================

Name: aes_dec_host

Overview:
- Initiator-side sequencer for the AES-128 decryption core's load/done interface.
- Accepts {key, ciphertext} requests on a valid/ready stream and issues `kld` (key load) to the core only when the key changes.
- Then issues `ld`, waits for `done`, and returns `text_out` on a valid/ready result stream.
- Sits between the system/bench request source and the decryption core. Processes one block at a time, with a done-timeout guard.

Parameters:
KEY_WAIT, 12, cycles to wait after the kld pulse before ld is allowed (core key-expansion time); legal range 1..255
TIMEOUT, 64, max cycles in DWAIT without done before error; legal range 2..1023

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_key  in  128  AES-128 key
in_data  in  128  ciphertext block
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  128  plaintext, or 0 on error
out_err  out  1  qualifies out_data; 1 = done timeout
kld  out  1  key-load pulse to core
ld  out  1  data-load pulse to core
key  out  128  key to core
text_in  out  128  ciphertext to core
done  in  1  core completion pulse
text_out  in  128  core plaintext, valid when done=1
busy  out  1  state != IDLE

Behaviour:
- All outputs are registered.
- Reset values, asserted at the first clk edge with rst=1 and taking priority over everything:
  - state=IDLE; in_ready=1; out_valid=0; out_err=0; out_data=0.
  - kld=0; ld=0; key=0; text_in=0; busy=0.
  - key cache invalid; counters 0.
- rst mid-operation abandons the block; no result is emitted. The core is not separately reset by this block.
- States: IDLE, KLOAD, KWAIT, DLOAD, DWAIT, OUT.
- IDLE:
  - in_ready=1.
  - On handshake, capture in_key and in_data.
  - If cache valid and in_key == cached key, go to DLOAD; otherwise go to KLOAD.
- KLOAD (1 cycle):
  - kld=1; key=captured key.
  - Cached key := captured key; cache valid := 1.
  - Load counter with KEY_WAIT-1; go to KWAIT.
- KWAIT:
  - Decrement the counter each cycle.
  - Leave for DLOAD in the cycle after the counter reads 0. KWAIT therefore lasts exactly KEY_WAIT cycles.
- DLOAD (1 cycle):
  - ld=1; text_in=captured data.
  - Clear timer; go to DWAIT.
- DWAIT:
  - Timer increments each cycle.
  - If done=1: out_data := text_out; out_err := 0; out_valid := 1; go to OUT.
  - Otherwise, if timer == TIMEOUT-1: out_data := 0; out_err := 1; out_valid := 1; cache valid := 0 (forces a key reload next time); go to OUT.
  - done wins if it coincides with the timeout cycle.
- OUT:
  - out_valid, out_data and out_err are held stable until out_ready=1.
  - On handshake: out_valid := 0 and go to IDLE. in_ready rises the next cycle; there is no bypass.
- Ordering and pulse rules:
  - kld and ld are never high in the same cycle.
  - Each is a single-cycle pulse.
  - key and text_in hold their last driven values while the pulses are low.
- Ignored inputs:
  - done outside DWAIT is ignored.
  - in_valid outside IDLE is ignored; in_ready=0 there.
- Cycle budget, request accepted at edge T:
  - Cached key: ld high in cycle T+1.
  - New key: kld high in T+1, ld high in T+2+KEY_WAIT.
  - done sampled at edge D gives out_valid high from D+1.
- Key compare is the full 128-bit equality against the cache.

Test Plan:
1. Reset, then request key=000102030405060708090a0b0c0d0e0f, data=69c4e0d86a7b0430d8cdb78070b4c55a, with a core model returning done 10 cycles after ld → exactly one kld, then ld exactly KEY_WAIT+1 cycles after kld; out_data=00112233445566778899aabbccddeeff, out_err=0.
2. Second request with the same key and the same data → no kld; ld in the cycle after acceptance; same out_data; kld count stays 1.
3. Third request with key=2b7e151628aed2a6abf7158809cf4f3c → kld reasserted with the new key; a subsequent request with the prior key also reasserts kld.
4. Hold out_ready=0 for 5 cycles after out_valid → out_valid and out_data stable; in_ready=0 and new in_valid ignored; accepted one cycle after the out handshake.
5. Core model never asserts done → out_valid with out_err=1 and out_data=0 exactly TIMEOUT cycles after ld; next request with the same key issues kld.
6. Assert rst during KWAIT, and separately during DWAIT with done arriving later → all outputs at reset values; the stray done is ignored; a new request runs normally starting with kld.

Source files
------------

// File: rtl/aes_dec_host_if.sv
// Request, result and core-side signals of the AES-128 decrypt host sequencer.
// master = the sequencer itself, slave = request source / result sink / core.
interface aes_dec_host_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_key;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_err;
   logic         kld;
   logic         ld;
   logic [127:0] key;
   logic [127:0] text_in;
   logic         done;
   logic [127:0] text_out;
   logic         busy;

   modport master (
      input  in_valid, in_key, in_data, out_ready, done, text_out,
      output in_ready, out_valid, out_data, out_err, kld, ld, key, text_in, busy
   );

   modport slave (
      output in_valid, in_key, in_data, out_ready, done, text_out,
      input  in_ready, out_valid, out_data, out_err, kld, ld, key, text_in, busy
   );
endinterface

// File: rtl/aes_dec_host.sv
// One-block-at-a-time sequencer for the AES-128 decrypt core: kld only on key change, ld 1 cycle after accept (cached key).
// All outputs registered; request side stalls (in_ready=0) from accept until the result handshake completes.
module aes_dec_host #(
   parameter int KEY_WAIT = 12,
   parameter int TIMEOUT  = 64
) (
   input logic            clk,
   input logic            rst,
   aes_dec_host_if.master bus
);

   typedef enum logic [2:0] {IDLE, KLOAD, KWAIT, DLOAD, DWAIT, OUT} state_t;

   state_t       state, state_nxt;
   logic [127:0] cap_key, cap_key_nxt;
   logic [127:0] cap_data, cap_data_nxt;
   logic [127:0] cache_key, cache_key_nxt;
   logic         cache_vld, cache_vld_nxt;
   logic [7:0]   cnt, cnt_nxt;
   logic [9:0]   tmr, tmr_nxt;

   logic         in_ready_r, in_ready_nxt;
   logic         out_valid_r, out_valid_nxt;
   logic         out_err_r, out_err_nxt;
   logic [127:0] out_data_r, out_data_nxt;
   logic         kld_r, kld_nxt;
   logic         ld_r, ld_nxt;
   logic [127:0] key_r, key_nxt;
   logic [127:0] text_r, text_nxt;
   logic         busy_r, busy_nxt;

   always_comb begin
      state_nxt     = state;
      cap_key_nxt   = cap_key;
      cap_data_nxt  = cap_data;
      cache_key_nxt = cache_key;
      cache_vld_nxt = cache_vld;
      cnt_nxt       = cnt;
      tmr_nxt       = tmr;
      out_valid_nxt = out_valid_r;
      out_err_nxt   = out_err_r;
      out_data_nxt  = out_data_r;
      key_nxt       = key_r;
      text_nxt      = text_r;

      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               cap_key_nxt  = bus.in_key;
               cap_data_nxt = bus.in_data;
               if (cache_vld && (bus.in_key == cache_key)) begin
                  state_nxt = DLOAD;
                  text_nxt  = bus.in_data;
               end else begin
                  state_nxt = KLOAD;
                  key_nxt   = bus.in_key;
               end
            end
         end
         KLOAD: begin
            cache_key_nxt = cap_key;
            cache_vld_nxt = 1'b1;
            cnt_nxt       = 8'(KEY_WAIT - 1);
            state_nxt     = KWAIT;
         end
         KWAIT: begin
            if (cnt == 8'd0) begin
               state_nxt = DLOAD;
               text_nxt  = cap_data;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         DLOAD: begin
            tmr_nxt   = 10'd0;
            state_nxt = DWAIT;
         end
         DWAIT: begin
            tmr_nxt = tmr + 10'd1;
            // done takes precedence over a timeout landing in the same cycle
            if (bus.done) begin
               out_data_nxt  = bus.text_out;
               out_err_nxt   = 1'b0;
               out_valid_nxt = 1'b1;
               state_nxt     = OUT;
            end else if (tmr == 10'(TIMEOUT - 1)) begin
               out_data_nxt  = '0;
               out_err_nxt   = 1'b1;
               out_valid_nxt = 1'b1;
               cache_vld_nxt = 1'b0;
               state_nxt     = OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               out_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      in_ready_nxt = (state_nxt == IDLE);
      busy_nxt     = (state_nxt != IDLE);
      kld_nxt      = (state_nxt == KLOAD);
      ld_nxt       = (state_nxt == DLOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cap_key     <= '0;
         cap_data    <= '0;
         cache_key   <= '0;
         cache_vld   <= 1'b0;
         cnt         <= '0;
         tmr         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_err_r   <= 1'b0;
         out_data_r  <= '0;
         kld_r       <= 1'b0;
         ld_r        <= 1'b0;
         key_r       <= '0;
         text_r      <= '0;
         busy_r      <= 1'b0;
      end else begin
         state       <= state_nxt;
         cap_key     <= cap_key_nxt;
         cap_data    <= cap_data_nxt;
         cache_key   <= cache_key_nxt;
         cache_vld   <= cache_vld_nxt;
         cnt         <= cnt_nxt;
         tmr         <= tmr_nxt;
         in_ready_r  <= in_ready_nxt;
         out_valid_r <= out_valid_nxt;
         out_err_r   <= out_err_nxt;
         out_data_r  <= out_data_nxt;
         kld_r       <= kld_nxt;
         ld_r        <= ld_nxt;
         key_r       <= key_nxt;
         text_r      <= text_nxt;
         busy_r      <= busy_nxt;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_err   = out_err_r;
   assign bus.out_data  = out_data_r;
   assign bus.kld       = kld_r;
   assign bus.ld        = ld_r;
   assign bus.key       = key_r;
   assign bus.text_in   = text_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_aes_dec_host.sv
// Directed bench for aes_dec_host with a behavioural decrypt-core model answering from known AES-128 vectors.
module tb_aes_dec_host;
   localparam int KW  = 12;
   localparam int TO  = 64;
   localparam int LAT = 10;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
   localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] BAD = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_dec_host_if bus ();

   aes_dec_host #(.KEY_WAIT(KW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int kld_cnt = 0, ld_cnt = 0, kld_cyc = 0, ld_cyc = 0;
   int acc_cyc = 0, out_cyc = 0;
   bit prev_kld = 1'b0, prev_ld = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Core model: latches key on kld, block on ld, answers LAT cycles later unless muted.
   int           core_cnt = 0;
   bit           core_mute = 1'b0;
   logic [127:0] core_key = '0, core_ct = '0;

   function automatic logic [127:0] decrypt(input logic [127:0] k, input logic [127:0] c);
      if (k == K1 && c == C1) return P1;
      if (k == K2 && c == C2) return P2;
      return BAD;
   endfunction

   always @(negedge clk) begin
      bus.done = 1'b0;
      if (bus.kld === 1'b1) core_key = bus.key;
      if (bus.ld === 1'b1) begin
         core_ct  = bus.text_in;
         core_cnt = LAT;
      end else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0 && !core_mute) begin
            bus.done     = 1'b1;
            bus.text_out = decrypt(core_key, core_ct);
         end
      end
   end

   always @(negedge clk) begin
      if (bus.kld === 1'b1) begin kld_cnt++; kld_cyc = cyc; end
      if (bus.ld === 1'b1) begin ld_cnt++; ld_cyc = cyc; end
      checks++;
      if ((bus.kld === 1'b1 && bus.ld === 1'b1) || (bus.kld === 1'b1 && prev_kld) ||
          (bus.ld === 1'b1 && prev_ld)) begin
         errors++;
         $display("FAIL pulse_rule kld=%0b ld=%0b prev_kld=%0b prev_ld=%0b required single non-overlapping pulses",
                  bus.kld, bus.ld, prev_kld, prev_ld);
      end
      prev_kld = (bus.kld === 1'b1);
      prev_ld  = (bus.ld === 1'b1);
   end

   task automatic req(input logic [127:0] k, input logic [127:0] d);
      int n = 0;
      bus.in_key   = k;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_accept in_ready=%b required 1", bus.in_ready);
      end
      acc_cyc = cyc;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input logic [127:0] exp_d, input logic exp_e, input string nm);
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      out_cyc = cyc;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_err !== exp_e) begin
         errors++;
         $display("FAIL %s_result out_valid=%b out_data=%h out_err=%b required 1 %h %b",
                  nm, bus.out_valid, bus.out_data, bus.out_err, exp_d, exp_e);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_release out_valid=%b in_ready=%b required 0 1", nm, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic check_reset_values(input string nm);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_err, bus.kld, bus.ld, bus.busy} !== 6'b100000) begin
         errors++;
         $display("FAIL %s_ctrl in_ready,out_valid,out_err,kld,ld,busy=%b required 100000", nm,
                  {bus.in_ready, bus.out_valid, bus.out_err, bus.kld, bus.ld, bus.busy});
      end
      checks++;
      if (bus.out_data !== '0 || bus.key !== '0 || bus.text_in !== '0) begin
         errors++;
         $display("FAIL %s_data out_data=%h key=%h text_in=%h required all 0", nm, bus.out_data, bus.key, bus.text_in);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
   endtask

   task automatic test_new_key();
      int k0 = kld_cnt;
      req(K1, C1);
      wait_out(P1, 1'b0, "new_key");
      checks++;
      if (kld_cnt - k0 != 1 || kld_cyc != acc_cyc + 1) begin
         errors++;
         $display("FAIL new_key_kld count=%0d at=%0d required 1 at %0d", kld_cnt - k0, kld_cyc, acc_cyc + 1);
      end
      checks++;
      if (ld_cyc - kld_cyc != KW + 1) begin
         errors++;
         $display("FAIL new_key_ld_gap gap=%0d required %0d", ld_cyc - kld_cyc, KW + 1);
      end
      checks++;
      if (out_cyc != ld_cyc + LAT + 1) begin
         errors++;
         $display("FAIL new_key_out_lat lat=%0d required %0d", out_cyc - ld_cyc, LAT + 1);
      end
   endtask

   task automatic test_cached_key();
      int k0 = kld_cnt;
      req(K1, C1);
      checks++;
      if (bus.ld !== 1'b1 || bus.kld !== 1'b0 || bus.text_in !== C1) begin
         errors++;
         $display("FAIL cached_ld ld=%b kld=%b text_in=%h required 1 0 %h", bus.ld, bus.kld, bus.text_in, C1);
      end
      wait_out(P1, 1'b0, "cached");
      checks++;
      if (kld_cnt != k0 || ld_cyc != acc_cyc + 1) begin
         errors++;
         $display("FAIL cached_kld_count extra_kld=%0d ld_at=%0d required 0 %0d", kld_cnt - k0, ld_cyc, acc_cyc + 1);
      end
   endtask

   task automatic test_key_change();
      int k0 = kld_cnt;
      req(K2, C2);
      checks++;
      if (bus.kld !== 1'b1 || bus.key !== K2) begin
         errors++;
         $display("FAIL key_change_kld kld=%b key=%h required 1 %h", bus.kld, bus.key, K2);
      end
      wait_out(P2, 1'b0, "key_change");
      req(K1, C1);
      wait_out(P1, 1'b0, "key_back");
      checks++;
      if (kld_cnt - k0 != 2 || bus.key !== K1 || bus.text_in !== C1) begin
         errors++;
         $display("FAIL key_back_kld kld_count=%0d key=%h text_in=%h required 2 %h %h",
                  kld_cnt - k0, bus.key, bus.text_in, K1, C1);
      end
   endtask

   task automatic test_backpressure();
      int n = 0;
      int k0, l0;
      req(K1, C1);
      while (bus.out_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      k0 = kld_cnt;
      l0 = ld_cnt;
      bus.in_key   = K2;
      bus.in_data  = C2;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== P1 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d out_valid=%b out_data=%h out_err=%b in_ready=%b required 1 %h 0 0",
                     i, bus.out_valid, bus.out_data, bus.out_err, bus.in_ready, P1);
         end
      end
      checks++;
      if (kld_cnt != k0 || ld_cnt != l0) begin
         errors++;
         $display("FAIL hold_ignored new_kld=%0d new_ld=%0d required 0 0", kld_cnt - k0, ld_cnt - l0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.kld !== 1'b1 || bus.key !== K2 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept kld=%b key=%h in_ready=%b required 1 %h 0", bus.kld, bus.key, bus.in_ready, K2);
      end
      wait_out(P2, 1'b0, "bp_next");
   endtask

   task automatic test_timeout();
      core_mute = 1'b1;
      req(K2, C2);
      wait_out('0, 1'b1, "timeout");
      checks++;
      // cycles spent waiting between the ld cycle and the first out_valid cycle
      if (out_cyc - ld_cyc - 1 != TO) begin
         errors++;
         $display("FAIL timeout_len waited=%0d required %0d", out_cyc - ld_cyc - 1, TO);
      end
      core_mute = 1'b0;
      req(K2, C2);
      checks++;
      if (bus.kld !== 1'b1 || bus.ld !== 1'b0) begin
         errors++;
         $display("FAIL timeout_reload kld=%b ld=%b required 1 0", bus.kld, bus.ld);
      end
      wait_out(P2, 1'b0, "timeout_recover");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      bit bad = 1'b0;
      req(K1, C1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("rst_kwait");
      rst = 1'b0;
      req(K1, C1);
      checks++;
      if (bus.kld !== 1'b1) begin
         errors++;
         $display("FAIL rst_kwait_reload kld=%b required 1", bus.kld);
      end
      while (bus.ld !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("rst_dwait");
      rst = 1'b0;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL stray_done out_valid=%b busy=%b in_ready=%b required 0 0 1 throughout",
                  bus.out_valid, bus.busy, bus.in_ready);
      end
      req(K1, C1);
      checks++;
      if (bus.kld !== 1'b1 || bus.key !== K1) begin
         errors++;
         $display("FAIL rst_dwait_reload kld=%b key=%h required 1 %h", bus.kld, bus.key, K1);
      end
      wait_out(P1, 1'b0, "rst_recover");
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_key    = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      bus.text_out  = '0;
      test_reset();
      test_new_key();
      test_cached_key();
      test_key_change();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
